// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared constants for the 3-stage pipeline controller: the 5-bit major
// opcodes (instruction bits [6:2]) already used by the core, the bubble
// instruction word, the PC-mux and write-back select encodings, the
// controller state encodings and the decoded-field record that the
// inst_fields decoder hands back to the controller.
package pipe_ctrl_pkg;

   // Major opcodes, taken from instruction bits [6:2]
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_ARI_I  = 5'b00100;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_ARI_R  = 5'b01100;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_CSR    = 5'b11100;

   // Bubble word: addi x0,x0,0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // PC mux select encodings
   localparam logic [1:0] PC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_ALU   = 2'd1;
   localparam logic [1:0] PC_RESET = 2'd2;
   localparam logic [1:0] PC_HOLD  = 2'd3;

   // Write-back select encodings
   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   // Controller states
   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   // Register indices and usage flags decoded from one instruction word
   typedef struct packed {
      logic [4:0] opcode;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       readsRs1;
      logic       readsRs2;
      logic       writesRd;
      logic       isCtrl;
   } inst_info_t;

endpackage

// File: rtl/pipe_ctrl_inst_fields.sv
// pipe_ctrl_inst_fields
// Purely combinational field decoder, used once per pipeline stage.
// Ports:
//   i_inst  in  32  instruction word of the stage
//   o_info  out     opcode, rs1/rs2/rd indices and the reads_rs1, reads_rs2,
//                   writes_rd (already excluding rd = x0) and is_ctrl flags
module pipe_ctrl_inst_fields
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] i_inst,
   output inst_info_t  o_info
);

   // funct fields and the fixed low bits play no part in hazard control
   logic w_unusedBits;
   assign w_unusedBits = ^{i_inst[31:25], i_inst[14:12], i_inst[1:0]};

   // Register usage by opcode; unknown opcodes neither read nor write
   always_comb begin
      o_info          = '0;
      o_info.opcode   = i_inst[6:2];
      o_info.rs1      = i_inst[19:15];
      o_info.rs2      = i_inst[24:20];
      o_info.rd       = i_inst[11:7];
      o_info.readsRs1 = (o_info.opcode inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
                                               OP_ARI_I, OP_ARI_R, OP_CSR});
      o_info.readsRs2 = (o_info.opcode inside {OP_BRANCH, OP_STORE, OP_ARI_R});
      // An rd of x0 is a discarded result, so it never counts as a write
      o_info.writesRd = (o_info.opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                                               OP_LOAD, OP_ARI_I, OP_ARI_R})
                        && (o_info.rd != 5'd0);
      o_info.isCtrl   = (o_info.opcode inside {OP_JAL, OP_JALR, OP_BRANCH});
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline controller for the 3-stage (IF / EX / MW) RISC-V core. Holds the
// EX and MW instruction words, sequences the PC mux through reset hold,
// not-taken prediction with a one-bubble redirect, and memory freezes, and
// drives the forwarding, register-file bypass and write-back controls.
// Ports:
//   clk          in   1   core clock
//   rst_n        in   1   asynchronous active-low reset
//   if_inst      in   32  IMEM read data for the PC chosen last cycle
//   ex_br_taken  in   1   branch comparator result for the EX instruction
//   mem_stall    in   1   data memory / IO busy, freezes the pipeline
//   pc_sel       out  2   0 PC+4, 1 ALU target, 2 reset vector, 3 hold
//   ex_inst      out  32  EX-stage instruction (NOP when bubbled)
//   ex_fwd_a/b   out  1   EX rs1/rs2 taken from the MW write-back value
//   if_byp_a/b   out  1   IF register read of rs1/rs2 bypassed from MW
//   mw_rf_we     out  1   register-file write enable for the MW instruction
//   mw_wb_sel    out  2   0 ALU result, 1 load data, 2 PC+4
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RESET_HOLD = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_inst,
   input  logic        ex_br_taken,
   input  logic        mem_stall,
   output logic [1:0]  pc_sel,
   output logic [31:0] ex_inst,
   output logic        ex_fwd_a,
   output logic        ex_fwd_b,
   output logic        if_byp_a,
   output logic        if_byp_b,
   output logic        mw_rf_we,
   output logic [1:0]  mw_wb_sel
);

   localparam int CW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

   logic [1:0]    r_state;
   logic [CW-1:0] r_holdCnt;
   logic [31:0]   r_exInst;
   logic [31:0]   r_mwInst;

   inst_info_t w_ifInfo;
   inst_info_t w_exInfo;
   inst_info_t w_mwInfo;

   logic w_running;
   logic w_freeze;
   logic w_redirect;

   pipe_ctrl_inst_fields u_ifFields (.i_inst(if_inst),  .o_info(w_ifInfo));
   pipe_ctrl_inst_fields u_exFields (.i_inst(r_exInst), .o_info(w_exInfo));
   pipe_ctrl_inst_fields u_mwFields (.i_inst(r_mwInst), .o_info(w_mwInfo));

   logic w_unusedInfo;
   assign w_unusedInfo = ^{w_ifInfo.opcode, w_ifInfo.rd, w_ifInfo.writesRd, w_ifInfo.isCtrl,
                           w_exInfo.rd, w_exInfo.writesRd,
                           w_mwInfo.rs1, w_mwInfo.rs2, w_mwInfo.readsRs1,
                           w_mwInfo.readsRs2, w_mwInfo.isCtrl};

   // The freeze acts in the very cycle mem_stall is seen, whether the state
   // register still says RUN or already says STALL; likewise the cycle in
   // which mem_stall drops while in STALL behaves as a RUN cycle, so a frozen
   // jump redirects immediately after the stall without an extra dead cycle.
   assign w_running  = (r_state != ST_HOLD);
   assign w_freeze   = w_running && mem_stall;
   assign w_redirect = w_running && !mem_stall && w_exInfo.isCtrl
                       && ((w_exInfo.opcode != OP_BRANCH) || ex_br_taken);

   assign ex_inst  = r_exInst;
   assign mw_rf_we = w_running && w_mwInfo.writesRd;
   assign ex_fwd_a = mw_rf_we && w_exInfo.readsRs1 && (w_exInfo.rs1 == w_mwInfo.rd);
   assign ex_fwd_b = mw_rf_we && w_exInfo.readsRs2 && (w_exInfo.rs2 == w_mwInfo.rd);
   assign if_byp_a = mw_rf_we && w_ifInfo.readsRs1 && (w_ifInfo.rs1 == w_mwInfo.rd);
   assign if_byp_b = mw_rf_we && w_ifInfo.readsRs2 && (w_ifInfo.rs2 == w_mwInfo.rd);

   // PC mux priority: reset vector during hold, then freeze, then redirect
   always_comb begin
      pc_sel = PC_PLUS4;
      if (!w_running) begin
         pc_sel = PC_RESET;
      end else if (w_freeze) begin
         pc_sel = PC_HOLD;
      end else if (w_redirect) begin
         pc_sel = PC_ALU;
      end
   end

   // Write-back source chosen from the MW opcode
   always_comb begin
      mw_wb_sel = WB_ALU;
      if (w_mwInfo.opcode == OP_LOAD) begin
         mw_wb_sel = WB_LOAD;
      end else if ((w_mwInfo.opcode == OP_JAL) || (w_mwInfo.opcode == OP_JALR)) begin
         mw_wb_sel = WB_PC4;
      end
   end

   // State and stage registers. HOLD flushes both stages while the counter
   // runs down; afterwards the stages advance unless frozen, with the EX
   // slot replaced by a bubble behind a redirect to kill the wrong path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_HOLD;
         r_holdCnt <= CW'(RESET_HOLD - 1);
         r_exInst  <= NOP_INST;
         r_mwInst  <= NOP_INST;
      end else begin
         case (r_state)
            ST_HOLD: begin
               r_exInst <= NOP_INST;
               r_mwInst <= NOP_INST;
               if (r_holdCnt == '0) begin
                  r_state <= ST_RUN;
               end else begin
                  r_holdCnt <= r_holdCnt - CW'(1);
               end
            end
            default: begin
               if (mem_stall) begin
                  r_state <= ST_STALL;
               end else begin
                  r_state  <= ST_RUN;
                  r_mwInst <= r_exInst;
                  r_exInst <= w_redirect ? NOP_INST : if_inst;
               end
            end
         endcase
      end
   end

endmodule
